// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core: one shared memory port and one ALU, sequenced by a
// Moore FSM through FETCH/DECODE/EXEC/MEM/WB. Every memory access uses a req/ready handshake.
module mc_cpu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              MUL_EN   = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            retire_o,
    output logic            trap_o,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      dbg_state
);
    // Memory handshake: mem_req_o rises with addr/we/wdata valid, and all of them hold
    // unchanged until a cycle with mem_ready_i high; that cycle completes the transfer.
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_MUL = 6'h18, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR = 6'h25, F_SLT = 6'h2A;

    state_t            state;
    logic [XLEN-1:0]   pc, a, b, imm, alu_out, mdr;
    logic [31:0]       ir;
    logic [XLEN-1:0]   regs [32];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, wb_dst;
    logic [XLEN-1:0]   imm_ir, alu_res, retire_pc, wb_data;
    logic              legal, do_retire;
    logic              unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign imm_ir       = {{(XLEN-16){ir[15]}}, ir[15:0]};
    assign wb_dst       = (op == OP_R) ? rd : rt;
    assign wb_data      = (op == OP_LW) ? mdr : alu_out;
    assign pc_o         = pc;
    assign dbg_state    = state;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
                    F_MUL:                            legal = MUL_EN;
                    default:                          legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    // Non-R instructions reaching EXEC (addi, lw, sw) all need A + imm.
    always_comb begin
        alu_res = a + imm;
        if (op == OP_R) begin
            case (funct)
                F_ADD:   alu_res = a + b;
                F_SUB:   alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = XLEN'($signed(a) < $signed(b));
                F_MUL:   alu_res = MUL_EN ? a * b : a + b;
                default: alu_res = a + b;
            endcase
        end
    end

    // PC is already incremented by the time j/beq resolve.
    always_comb begin
        retire_pc = pc;
        if (state == S_DECODE)
            retire_pc = {pc[XLEN-1:28], ir[25:0], 2'b00};
        else if (state == S_EXEC && a == b)
            retire_pc = pc + {imm[XLEN-3:0], 2'b00};
    end

    always_comb begin
        do_retire = 1'b0;
        case (state)
            S_DECODE: do_retire = legal && (op == OP_J);
            S_EXEC:   do_retire = (op == OP_BEQ);
            S_MEM:    do_retire = mem_ready_i && (op == OP_SW);
            S_WB:     do_retire = 1'b1;
            default:  do_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            imm         <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            retire_o    <= 1'b0;
            trap_o      <= 1'b0;
        end else begin
            retire_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_FETCH;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= pc;
                    end
                end
                S_FETCH: begin
                    if (mem_ready_i) begin
                        ir        <= mem_rdata_i[31:0];
                        pc        <= pc + XLEN'(4);
                        mem_req_o <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a   <= regs[rs];
                    b   <= regs[rt];
                    imm <= imm_ir;
                    if (!legal) begin
                        state  <= S_HALT;
                        trap_o <= 1'b1;
                    end else if (op != OP_J) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (op == OP_LW || op == OP_SW) begin
                        if (alu_res[1:0] != 2'b00) begin
                            state  <= S_HALT;
                            trap_o <= 1'b1;
                        end else begin
                            state       <= S_MEM;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= (op == OP_SW);
                            mem_addr_o  <= alu_res;
                            mem_wdata_o <= b;
                        end
                    end else if (op != OP_BEQ) begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mdr       <= mem_rdata_i;
                        state     <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
                end
                S_HALT: begin
                    mem_req_o <= 1'b0;
                end
                default: state <= S_HALT;
            endcase

            // Instruction boundary: start_i decides between the next fetch and IDLE.
            if (do_retire) begin
                retire_o   <= 1'b1;
                pc         <= retire_pc;
                mem_addr_o <= retire_pc;
                mem_we_o   <= 1'b0;
                mem_req_o  <= start_i;
                state      <= start_i ? S_FETCH : S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mc_cpu.sv
// Bench for mc_cpu: a 32-bit core and a 64-bit no-mul core share one memory model;
// retire and store events are scored against expected queues filled per program.
module tb_mc_cpu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start, ready, sel;
    logic [63:0] rdata;
    logic        req_a, we_a, ret_a, trap_a;
    logic [31:0] addr_a, wdata_a, pc_a;
    logic [2:0]  st_a, st_b;
    logic        req_b, we_b, ret_b, trap_b;
    logic [63:0] addr_b, wdata_b, pc_b;

    mc_cpu #(.XLEN(32), .RESET_PC(32'h0), .MUL_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start),
        .mem_req_o(req_a), .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a),
        .mem_rdata_i(rdata[31:0]), .mem_ready_i(ready),
        .retire_o(ret_a), .trap_o(trap_a), .pc_o(pc_a), .dbg_state(st_a)
    );

    mc_cpu #(.XLEN(64), .RESET_PC(64'h0), .MUL_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start),
        .mem_req_o(req_b), .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
        .mem_rdata_i(rdata), .mem_ready_i(ready),
        .retire_o(ret_b), .trap_o(trap_b), .pc_o(pc_b), .dbg_state(st_b)
    );

    logic        m_req, m_we, m_ret, m_trap, m_rst;
    logic [63:0] m_addr, m_wdata, m_pc;
    assign m_rst   = sel ? rst_b   : rst_a;
    assign m_req   = sel ? req_b   : req_a;
    assign m_we    = sel ? we_b    : we_a;
    assign m_ret   = sel ? ret_b   : ret_a;
    assign m_trap  = sel ? trap_b  : trap_a;
    assign m_addr  = sel ? addr_b  : {32'd0, addr_a};
    assign m_wdata = sel ? wdata_b : {32'd0, wdata_a};
    assign m_pc    = sel ? pc_b    : {32'd0, pc_a};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;
    int delay = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    logic [63:0] ret_pc_q[$];
    int          ret_t_q[$];
    logic [63:0] st_addr_q[$];
    logic [63:0] st_data_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model with a fixed number of wait cycles, plus the retire/store monitors.
    int          cnt = 0;
    logic        busy = 1'b0;
    logic        h_we;
    logic [63:0] h_addr, h_wdata, e_pc, e_a, e_d;
    int          e_t;
    always @(negedge clk) begin
        if (m_rst) begin
            ready = 1'b0;
            cnt   = 0;
            busy  = 1'b0;
        end else begin
            if (ready) begin
                if (h_we) begin
                    mem[h_addr[9:2]] = h_wdata[31:0];
                    check("store_avail", 64'(st_addr_q.size() > 0), 64'd1);
                    if (st_addr_q.size() > 0) begin
                        e_a = st_addr_q.pop_front();
                        e_d = st_data_q.pop_front();
                        check("store_addr", h_addr, e_a);
                        check("store_data", h_wdata, e_d);
                    end
                end
                ready = 1'b0;
                cnt   = 0;
                busy  = 1'b0;
            end
            if (m_req) begin
                if (!busy) begin
                    busy    = 1'b1;
                    h_addr  = m_addr;
                    h_we    = m_we;
                    h_wdata = m_wdata;
                end else begin
                    check("req_addr_stable", m_addr, h_addr);
                    check("req_we_stable", 64'(m_we), 64'(h_we));
                    if (h_we) check("req_wdata_stable", m_wdata, h_wdata);
                end
                rdata = {32'd0, mem[m_addr[9:2]]};
                if (cnt >= delay) ready = 1'b1;
                else cnt++;
            end
            if (m_ret) begin
                check("retire_avail", 64'(ret_pc_q.size() > 0), 64'd1);
                if (ret_pc_q.size() > 0) begin
                    e_pc = ret_pc_q.pop_front();
                    e_t  = ret_t_q.pop_front();
                    check("retire_pc", m_pc, e_pc);
                    check("retire_cycle", 64'(cyc - base), 64'(e_t));
                end
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] funct, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_ins(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[9:2]] = w;
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask
    task automatic exp_ret(input logic [63:0] pc, input int t);
        ret_pc_q.push_back(pc);
        ret_t_q.push_back(t);
    endtask
    task automatic exp_st(input logic [63:0] addr, input logic [63:0] data);
        st_addr_q.push_back(addr);
        st_data_q.push_back(data);
    endtask
    task automatic reset_a();
        start = 1'b0;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
    endtask
    task automatic go();
        @(negedge clk);
        start = 1'b1;
        base  = cyc + 1;
    endtask
    task automatic drain(input int budget);
        int n = 0;
        while ((ret_pc_q.size() + st_addr_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(ret_pc_q.size() + st_addr_q.size()), 64'd0);
        ret_pc_q.delete();
        ret_t_q.delete();
        st_addr_q.delete();
        st_data_q.delete();
    endtask
    task automatic halt_check(input int wait_cycles);
        repeat (wait_cycles) @(negedge clk);
        check("trap", 64'(m_trap), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("halt_req", 64'(m_req), 64'd0);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start = 1'b0; sel = 1'b0; ready = 1'b0; rdata = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_req", 64'(req_a), 64'd0);
        check("rst_we", 64'(we_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_wdata", 64'(wdata_a), 64'd0);
        check("rst_retire", 64'(ret_a), 64'd0);
        check("rst_trap", 64'(trap_a), 64'd0);
        check("rst_pc", 64'(pc_a), 64'd0);
        check("rst_pc64", pc_b, 64'd0);

        // ALU program, zero-wait memory; results dumped with sw.
        put(32'h00, i_ins(6'h08, 5'd1, 5'd0, 16'd5));
        put(32'h04, i_ins(6'h08, 5'd2, 5'd0, 16'hFFFD));
        put(32'h08, r_ins(6'h20, 5'd3, 5'd1, 5'd2));
        put(32'h0C, r_ins(6'h22, 5'd4, 5'd2, 5'd1));
        put(32'h10, r_ins(6'h2A, 5'd5, 5'd2, 5'd1));
        put(32'h14, i_ins(6'h2B, 5'd3, 5'd0, 16'h0100));
        put(32'h18, i_ins(6'h2B, 5'd4, 5'd0, 16'h0104));
        put(32'h1C, i_ins(6'h2B, 5'd5, 5'd0, 16'h0108));
        put(32'h20, r_ins(6'h18, 5'd6, 5'd1, 5'd2));
        put(32'h24, r_ins(6'h24, 5'd7, 5'd1, 5'd2));
        put(32'h28, r_ins(6'h25, 5'd8, 5'd1, 5'd2));
        put(32'h2C, i_ins(6'h2B, 5'd6, 5'd0, 16'h010C));
        put(32'h30, i_ins(6'h2B, 5'd7, 5'd0, 16'h0110));
        put(32'h34, i_ins(6'h2B, 5'd8, 5'd0, 16'h0114));
        for (int i = 1; i <= 14; i++) exp_ret(64'(4 * i), 4 * i);
        exp_st(64'h100, 64'h2);
        exp_st(64'h104, 64'hFFFF_FFF8);
        exp_st(64'h108, 64'h1);
        exp_st(64'h10C, 64'hFFFF_FFF1);
        exp_st(64'h110, 64'h5);
        exp_st(64'h114, 64'hFFFF_FFFD);
        rst_a = 1'b0;
        go();
        drain(200);
        halt_check(6);

        // Store then load with three wait cycles on every access.
        reset_a();
        clear_mem();
        delay = 3;
        put(32'h00, i_ins(6'h08, 5'd1, 5'd0, 16'd5));
        put(32'h04, i_ins(6'h2B, 5'd1, 5'd0, 16'h0080));
        put(32'h08, i_ins(6'h23, 5'd6, 5'd0, 16'h0080));
        put(32'h0C, i_ins(6'h2B, 5'd6, 5'd0, 16'h0084));
        exp_ret(64'h04, 7);
        exp_ret(64'h08, 17);
        exp_ret(64'h0C, 28);
        exp_ret(64'h10, 38);
        exp_st(64'h80, 64'h5);
        exp_st(64'h84, 64'h5);
        go();
        drain(200);
        halt_check(10);
        delay = 0;

        // Branches and jumps.
        reset_a();
        clear_mem();
        put(32'h00, i_ins(6'h08, 5'd1, 5'd0, 16'd1));
        put(32'h04, i_ins(6'h08, 5'd2, 5'd0, 16'd2));
        put(32'h08, i_ins(6'h04, 5'd2, 5'd1, 16'd5));
        put(32'h0C, j_ins(26'h4));
        put(32'h10, i_ins(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h14, ILLEGAL);
        put(32'h18, ILLEGAL);
        put(32'h1C, j_ins(26'h40));
        put(32'h100, i_ins(6'h2B, 5'd1, 5'd0, 16'h0180));
        put(32'h104, ILLEGAL);
        exp_ret(64'h04, 4);
        exp_ret(64'h08, 8);
        exp_ret(64'h0C, 11);
        exp_ret(64'h10, 13);
        exp_ret(64'h1C, 16);
        exp_ret(64'h100, 18);
        exp_ret(64'h104, 22);
        exp_st(64'h180, 64'h1);
        go();
        drain(200);
        halt_check(6);

        // r0 stays zero; misaligned load halts without a request.
        reset_a();
        clear_mem();
        put(32'h00, i_ins(6'h08, 5'd0, 5'd0, 16'd7));
        put(32'h04, r_ins(6'h20, 5'd7, 5'd0, 5'd0));
        put(32'h08, i_ins(6'h2B, 5'd7, 5'd0, 16'h0080));
        put(32'h0C, i_ins(6'h08, 5'd9, 5'd0, 16'd2));
        put(32'h10, i_ins(6'h23, 5'd10, 5'd9, 16'd0));
        exp_ret(64'h04, 4);
        exp_ret(64'h08, 8);
        exp_ret(64'h0C, 12);
        exp_ret(64'h10, 16);
        exp_st(64'h80, 64'h0);
        go();
        drain(200);
        halt_check(6);

        // start_i dropped mid-instruction: complete, idle with PC held, then resume.
        reset_a();
        clear_mem();
        put(32'h00, i_ins(6'h08, 5'd1, 5'd0, 16'd9));
        put(32'h04, i_ins(6'h2B, 5'd1, 5'd0, 16'h0080));
        exp_ret(64'h04, 4);
        go();
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain(50);
        repeat (5) @(negedge clk);
        check("idle_pc", 64'(pc_a), 64'h04);
        check("idle_req", 64'(req_a), 64'd0);
        exp_ret(64'h08, 4);
        exp_st(64'h80, 64'h9);
        go();
        drain(50);
        halt_check(6);

        // Reset during a fetch wait state.
        reset_a();
        clear_mem();
        delay = 3;
        put(32'h00, i_ins(6'h08, 5'd1, 5'd0, 16'h0055));
        put(32'h04, i_ins(6'h08, 5'd2, 5'd0, 16'd1));
        exp_ret(64'h04, 7);
        go();
        drain(50);
        @(negedge clk);
        #2;
        check("fetch_wait_req", 64'(req_a), 64'd1);
        rst_a = 1'b1;
        start = 1'b0;
        #1;
        check("rst_mid_req", 64'(req_a), 64'd0);
        check("rst_mid_pc", 64'(pc_a), 64'd0);
        repeat (2) @(negedge clk);
        clear_mem();
        delay = 0;
        put(32'h00, i_ins(6'h2B, 5'd1, 5'd0, 16'h0080));
        put(32'h04, i_ins(6'h2B, 5'd2, 5'd0, 16'h0084));
        exp_ret(64'h04, 4);
        exp_ret(64'h08, 8);
        exp_st(64'h80, 64'h0);
        exp_st(64'h84, 64'h0);
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_mid_trap", 64'(trap_a), 64'd0);
        go();
        drain(100);
        halt_check(6);

        // 64-bit core without mul.
        start = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        clear_mem();
        put(32'h00, i_ins(6'h23, 5'd1, 5'd0, 16'h0080));
        put(32'h04, i_ins(6'h08, 5'd2, 5'd0, 16'd1));
        put(32'h08, r_ins(6'h20, 5'd3, 5'd1, 5'd2));
        put(32'h0C, i_ins(6'h2B, 5'd3, 5'd0, 16'h0088));
        put(32'h10, i_ins(6'h08, 5'd4, 5'd0, 16'hFFFF));
        put(32'h14, i_ins(6'h2B, 5'd4, 5'd0, 16'h0090));
        put(32'h18, r_ins(6'h18, 5'd5, 5'd1, 5'd2));
        put(32'h80, 32'h7FFF_FFFF);
        exp_ret(64'h04, 5);
        exp_ret(64'h08, 9);
        exp_ret(64'h0C, 13);
        exp_ret(64'h10, 17);
        exp_ret(64'h14, 21);
        exp_ret(64'h18, 25);
        exp_st(64'h88, 64'h0000_0000_8000_0000);
        exp_st(64'h90, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        go();
        drain(200);
        halt_check(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
